data_stack: RTL

DATA_STACK -- requirements
Module: data_stack

---
 rtl/forthsuper_pkg.sv | 15 +
 rtl/ss_io.sv | 15 +
 rtl/ss_ram.sv | 21 ++
 rtl/data_stack.sv | 105 ++++++++++
 4 files changed

// File: rtl/forthsuper_pkg.sv
// Shared definitions for the Forth data-stack datapath: stack op encoding
// and default geometry.
package forthsuper_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    PUSH = 2'b01,
    POP  = 2'b10,
    PICK = 2'b11
  } stack_ops;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 64;

endpackage

// File: rtl/ss_io.sv
// Stack command/result bundle between a stack user (master) and the stack.
// One op is issued per clock: op and vi are sampled at every posedge with no
// valid/ready handshake (the stack never stalls); s returns the current TOS.
interface ss_io
  import forthsuper_pkg::*;
#(
  parameter int DW = DEF_DW
);
  stack_ops        op;
  logic [DW-1:0]   vi;
  logic [DW-1:0]   s;

  modport master (output op, output vi, input s);
  modport slave  (input op, input vi, output s);
endinterface

// File: rtl/ss_ram.sv
// Storage for the stack cells below TOS: DW x (DEPTH-1), one synchronous
// write port and one asynchronous read port.
module ss_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem_q [DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/data_stack.sv
// Forth data stack with a registered TOS, single-cycle PUSH/POP/PICK and
// sticky overflow/underflow flags.
module data_stack
  import forthsuper_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  ss_io.slave                      io,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     udf
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] s_q, s_d;
  logic [AW:0]   depth_q, depth_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          ovf_set, udf_set;

  logic          we;
  logic [AW-1:0] waddr, raddr, d_lo, n;
  logic [DW-1:0] rdata;

  // Low bits of depth are enough for addressing: modular arithmetic gives
  // the right slot even when depth==DEPTH wraps d_lo to zero.
  assign d_lo = depth_q[AW-1:0];
  assign n    = io.vi[AW-1:0];

  ss_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (s_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    s_d     = s_q;
    depth_d = depth_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    we      = 1'b0;
    waddr   = d_lo - AW'(1);
    raddr   = d_lo - AW'(2);
    unique case (io.op)
      PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = (depth_q != '0);
          s_d     = io.vi;
          depth_d = depth_q + (AW+1)'(1);
        end
      end
      POP: begin
        if (empty) begin
          udf_set = 1'b1;
        end else if (depth_q == (AW+1)'(1)) begin
          s_d     = '0;
          depth_d = '0;
        end else begin
          s_d     = rdata;
          depth_d = depth_q - (AW+1)'(1);
        end
      end
      PICK: begin
        raddr = d_lo - AW'(1) - n;
        if ({1'b0, n} >= depth_q) udf_set = 1'b1;
        else if (n != '0)         s_d     = rdata;
      end
      default: ;
    endcase
    // A flag raised this cycle beats a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    udf_d = udf_set | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign io.s  = s_q;
  assign depth = depth_q;
  assign empty = (depth_q == '0);
  assign full  = (depth_q == (AW+1)'(DEPTH));
  assign ovf   = ovf_q;
  assign udf   = udf_q;
endmodule
